// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle control unit for the MCPU: sequences RAM, IR, PC, register file
// and ALU through fetch/decode/execute/memory/writeback, halting on errors.
module mcpu_ctrl_fsm #(
  parameter int                     OPCODE_SIZE      = 4,
  parameter logic [OPCODE_SIZE-1:0] OP_MOV           = OPCODE_SIZE'(0),
  parameter logic [OPCODE_SIZE-1:0] OP_ADD           = OPCODE_SIZE'(1),
  parameter logic [OPCODE_SIZE-1:0] OP_XOR           = OPCODE_SIZE'(2),
  parameter logic [OPCODE_SIZE-1:0] OP_SHORT_TO_REG  = OPCODE_SIZE'(3),
  parameter logic [OPCODE_SIZE-1:0] OP_LOAD_FROM_MEM = OPCODE_SIZE'(4),
  parameter logic [OPCODE_SIZE-1:0] OP_STORE_TO_MEM  = OPCODE_SIZE'(5),
  parameter logic [OPCODE_SIZE-1:0] OP_BNZ           = OPCODE_SIZE'(6),
  parameter int                     MEM_TIMEOUT      = 15,
  parameter int                     CNT_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   rf_a_zero,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_addr_sel,
  output logic                   ir_load,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   rf_we,
  output logic [1:0]             rf_wsrc,
  output logic [1:0]             alu_op,
  output logic                   halted,
  output logic [1:0]             err_code,
  output logic [CNT_WIDTH-1:0]   retired,
  output logic [2:0]             dbg_state
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic                   halted_q, halted_d;
  logic [1:0]             err_q, err_d;
  logic [OPCODE_SIZE-1:0] opcode_q, opcode_d;

  logic       req_c, we_c, asel_c, irl_c, pci_c, pcl_c, rfwe_c;
  logic [1:0] wsrc_c, alu_c, alu_sel, wsrc_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      err_q     <= 2'b00;
      opcode_q  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
      opcode_q  <= opcode_d;
    end
  end

  // RAM handshake: mem_req and its qualifiers (mem_we, mem_addr_sel) hold
  // steady until a cycle where mem_req && mem_ready; that cycle completes the
  // access. mem_ready without mem_req is ignored. The wait counter counts
  // cycles with mem_req high and mem_ready low, and is zero in every other
  // state, so it is always clear on entry to FETCH or MEM.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    retired_d = retired_q;
    halted_d  = halted_q;
    err_d     = err_q;
    opcode_d  = opcode_q;
    req_c     = 1'b0;
    we_c      = 1'b0;
    asel_c    = 1'b0;
    irl_c     = 1'b0;
    pci_c     = 1'b0;
    pcl_c     = 1'b0;
    rfwe_c    = 1'b0;
    wsrc_c    = 2'b00;
    alu_c     = 2'b00;

    alu_sel  = (opcode_q == OP_ADD) ? 2'b01 :
               (opcode_q == OP_XOR) ? 2'b10 : 2'b00;
    wsrc_sel = (opcode_q == OP_SHORT_TO_REG)  ? 2'b01 :
               (opcode_q == OP_LOAD_FROM_MEM) ? 2'b10 : 2'b00;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          irl_c   = 1'b1;
          pci_c   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          err_d    = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_MOV, OP_ADD, OP_XOR, OP_SHORT_TO_REG, OP_BNZ: state_d = S_EXEC;
          OP_LOAD_FROM_MEM, OP_STORE_TO_MEM:               state_d = S_MEM;
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            err_d    = 2'b01;
          end
        endcase
      end

      S_EXEC: begin
        if (opcode_q == OP_BNZ) begin
          pcl_c     = ~rf_a_zero;
          retired_d = retired_q + CNT_WIDTH'(1);
          state_d   = S_FETCH;
        end else begin
          alu_c   = alu_sel;
          wsrc_c  = wsrc_sel;
          state_d = S_WB;
        end
      end

      S_MEM: begin
        req_c  = 1'b1;
        asel_c = 1'b1;
        we_c   = (opcode_q == OP_STORE_TO_MEM);
        if (mem_ready) begin
          if (opcode_q == OP_STORE_TO_MEM) begin
            retired_d = retired_q + CNT_WIDTH'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          err_d    = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        rfwe_c    = 1'b1;
        wsrc_c    = wsrc_sel;
        alu_c     = alu_sel;
        retired_d = retired_q + CNT_WIDTH'(1);
        state_d   = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
    endcase
  end

  // Strobes are gated by reset so an in-flight instruction has no side effect.
  assign mem_req      = req_c  & ~reset;
  assign mem_we       = we_c   & ~reset;
  assign mem_addr_sel = asel_c & ~reset;
  assign ir_load      = irl_c  & ~reset;
  assign pc_inc       = pci_c  & ~reset;
  assign pc_load      = pcl_c  & ~reset;
  assign rf_we        = rfwe_c & ~reset;
  assign rf_wsrc      = reset ? 2'b00 : wsrc_c;
  assign alu_op       = reset ? 2'b00 : alu_c;
  assign halted       = halted_q;
  assign err_code     = err_q;
  assign retired      = retired_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: fixed vector table, hand-built corner sequences, and
// random instruction streams expanded into per-cycle expectations by a model.
module tb_mcpu_ctrl_fsm;

  // Output word: {req, we, asel, ir_load, pc_inc, pc_load, rf_we, wsrc[2], alu[2], halted, err[2]}
  localparam logic [13:0] O_REQ     = 14'h2000;
  localparam logic [13:0] O_WE      = 14'h1000;
  localparam logic [13:0] O_ASEL    = 14'h0800;
  localparam logic [13:0] O_IRL     = 14'h0400;
  localparam logic [13:0] O_PCI     = 14'h0200;
  localparam logic [13:0] O_PCL     = 14'h0100;
  localparam logic [13:0] O_RFWE    = 14'h0080;
  localparam logic [13:0] O_WS_RAM  = 14'h0040;
  localparam logic [13:0] O_WS_IMM  = 14'h0020;
  localparam logic [13:0] O_ALU_XOR = 14'h0010;
  localparam logic [13:0] O_ALU_ADD = 14'h0008;
  localparam logic [13:0] O_HALT    = 14'h0004;
  localparam logic [13:0] O_E_TO    = 14'h0002;
  localparam logic [13:0] O_E_ILL   = 14'h0001;
  localparam logic [13:0] O_FETCHED = O_REQ | O_IRL | O_PCI;
  localparam logic [13:0] M_ALL     = 14'h3fff;
  localparam logic [13:0] M_STROBE  = 14'h3ff8;

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                         ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd5;

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [13:0] exp;
    logic [2:0]  st;
    logic [15:0] ret;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic        rf_a_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load, rf_we, halted;
  logic [1:0]  rf_wsrc, alu_op, err_code;
  logic [15:0] retired;
  logic [2:0]  dbg_state;
  logic [13:0] outs;

  int checks = 0;
  int errors = 0;
  vec_t tbl[28];
  vec_t trace_q[$];
  logic [15:0] ret_m;

  always #5 clk = ~clk;

  mcpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rf_a_zero(rf_a_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .rf_we(rf_we), .rf_wsrc(rf_wsrc), .alu_op(alu_op),
    .halted(halted), .err_code(err_code), .retired(retired),
    .dbg_state(dbg_state)
  );

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
                 rf_we, rf_wsrc, alu_op, halted, err_code};

  function automatic vec_t mk(input logic [3:0] op, input logic z, input logic rdy,
                              input logic [13:0] exp, input logic [2:0] st,
                              input logic [15:0] ret);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.st = st; v.ret = ret;
    return v;
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 65) return 0;
    if (r < 95) return int'($urandom_range(1, 4));
    return 14;
  endfunction

  // Reference model: one instruction expands into its cycle-by-cycle trace.
  function automatic void gen_instr(input logic [3:0] op, input logic z,
                                    input int df, input int dm);
    logic [13:0] alu, mq;
    for (int i = 0; i < df; i++) trace_q.push_back(mk(r4(), r1(), 1'b0, O_REQ, ST_F, ret_m));
    trace_q.push_back(mk(r4(), r1(), 1'b1, O_FETCHED, ST_F, ret_m));
    trace_q.push_back(mk(op, r1(), r1(), 14'h0, ST_D, ret_m));
    case (op)
      4'd0, 4'd1, 4'd2: begin
        alu = (op == 4'd1) ? O_ALU_ADD : (op == 4'd2) ? O_ALU_XOR : 14'h0;
        trace_q.push_back(mk(op, r1(), r1(), alu, ST_E, ret_m));
        trace_q.push_back(mk(op, r1(), r1(), O_RFWE | alu, ST_W, ret_m));
      end
      4'd3: begin
        trace_q.push_back(mk(op, r1(), r1(), O_WS_IMM, ST_E, ret_m));
        trace_q.push_back(mk(op, r1(), r1(), O_RFWE | O_WS_IMM, ST_W, ret_m));
      end
      4'd6: trace_q.push_back(mk(op, z, r1(), z ? 14'h0 : O_PCL, ST_E, ret_m));
      default: begin
        mq = (op == 4'd5) ? (O_REQ | O_WE | O_ASEL) : (O_REQ | O_ASEL);
        for (int i = 0; i < dm; i++) trace_q.push_back(mk(op, r1(), 1'b0, mq, ST_M, ret_m));
        trace_q.push_back(mk(op, r1(), 1'b1, mq, ST_M, ret_m));
        if (op == 4'd4) trace_q.push_back(mk(op, r1(), r1(), O_RFWE | O_WS_RAM, ST_W, ret_m));
      end
    endcase
    ret_m = ret_m + 16'd1;
  endfunction

  task automatic run_vec(input vec_t v, input logic [13:0] mask, input bit full);
    opcode    = v.op;
    rf_a_zero = v.z;
    mem_ready = v.rdy;
    @(negedge clk);
    checks++;
    if ((outs & mask) !== (v.exp & mask)) begin
      errors++;
      $display("FAIL outputs: got %h expected %h (op %0d state %0d)",
               outs & mask, v.exp & mask, v.op, v.st);
    end
    if (full) begin
      checks++;
      if (dbg_state !== v.st) begin
        errors++;
        $display("FAIL state: got %0d expected %0d", dbg_state, v.st);
      end
      checks++;
      if (retired !== v.ret) begin
        errors++;
        $display("FAIL retired: got %0d expected %0d", retired, v.ret);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) run_vec(mk(r4(), r1(), r1(), 14'h0, ST_F, 16'd0), M_STROBE, 1'b0);
    reset = 1'b0;
  endtask

  task automatic drain();
    while (trace_q.size() > 0) run_vec(trace_q.pop_front(), M_ALL, 1'b1);
  endtask

  initial begin
    // SHORT, ADD, XOR, BNZ taken, BNZ not taken, STORE with 3 waits, LOAD.
    tbl[0]  = mk(4'd3, 1'b0, 1'b1, O_FETCHED,             ST_F, 16'd0);
    tbl[1]  = mk(4'd3, 1'b0, 1'b1, 14'h0,                 ST_D, 16'd0);
    tbl[2]  = mk(4'd3, 1'b1, 1'b1, O_WS_IMM,              ST_E, 16'd0);
    tbl[3]  = mk(4'd3, 1'b0, 1'b0, O_RFWE | O_WS_IMM,     ST_W, 16'd0);
    tbl[4]  = mk(4'd1, 1'b0, 1'b1, O_FETCHED,             ST_F, 16'd1);
    tbl[5]  = mk(4'd1, 1'b0, 1'b0, 14'h0,                 ST_D, 16'd1);
    tbl[6]  = mk(4'd1, 1'b0, 1'b0, O_ALU_ADD,             ST_E, 16'd1);
    tbl[7]  = mk(4'd1, 1'b0, 1'b0, O_RFWE | O_ALU_ADD,    ST_W, 16'd1);
    tbl[8]  = mk(4'd2, 1'b0, 1'b1, O_FETCHED,             ST_F, 16'd2);
    tbl[9]  = mk(4'd2, 1'b0, 1'b0, 14'h0,                 ST_D, 16'd2);
    tbl[10] = mk(4'd2, 1'b0, 1'b0, O_ALU_XOR,             ST_E, 16'd2);
    tbl[11] = mk(4'd2, 1'b0, 1'b1, O_RFWE | O_ALU_XOR,    ST_W, 16'd2);
    tbl[12] = mk(4'd6, 1'b0, 1'b1, O_FETCHED,             ST_F, 16'd3);
    tbl[13] = mk(4'd6, 1'b0, 1'b1, 14'h0,                 ST_D, 16'd3);
    tbl[14] = mk(4'd6, 1'b0, 1'b0, O_PCL,                 ST_E, 16'd3);
    tbl[15] = mk(4'd6, 1'b1, 1'b1, O_FETCHED,             ST_F, 16'd4);
    tbl[16] = mk(4'd6, 1'b1, 1'b0, 14'h0,                 ST_D, 16'd4);
    tbl[17] = mk(4'd6, 1'b1, 1'b1, 14'h0,                 ST_E, 16'd4);
    tbl[18] = mk(4'd5, 1'b0, 1'b1, O_FETCHED,             ST_F, 16'd5);
    tbl[19] = mk(4'd5, 1'b0, 1'b0, 14'h0,                 ST_D, 16'd5);
    tbl[20] = mk(4'd5, 1'b0, 1'b0, O_REQ | O_WE | O_ASEL, ST_M, 16'd5);
    tbl[21] = mk(4'd5, 1'b0, 1'b0, O_REQ | O_WE | O_ASEL, ST_M, 16'd5);
    tbl[22] = mk(4'd5, 1'b0, 1'b0, O_REQ | O_WE | O_ASEL, ST_M, 16'd5);
    tbl[23] = mk(4'd5, 1'b0, 1'b1, O_REQ | O_WE | O_ASEL, ST_M, 16'd5);
    tbl[24] = mk(4'd4, 1'b0, 1'b1, O_FETCHED,             ST_F, 16'd6);
    tbl[25] = mk(4'd4, 1'b0, 1'b0, 14'h0,                 ST_D, 16'd6);
    tbl[26] = mk(4'd4, 1'b0, 1'b1, O_REQ | O_ASEL,        ST_M, 16'd6);
    tbl[27] = mk(4'd4, 1'b0, 1'b0, O_RFWE | O_WS_RAM,     ST_W, 16'd6);

    @(posedge clk);
    #1;
    do_reset(3);
    for (int i = 0; i < 28; i++) run_vec(tbl[i], M_ALL, 1'b1);

    // Illegal opcode 4'hF: sticky halt, retired frozen at 7.
    run_vec(mk(r4(), r1(), 1'b1, O_FETCHED, ST_F, 16'd7), M_ALL, 1'b1);
    run_vec(mk(4'hF, r1(), r1(), 14'h0, ST_D, 16'd7), M_ALL, 1'b1);
    for (int i = 0; i < 20; i++)
      run_vec(mk(r4(), r1(), r1(), O_HALT | O_E_ILL, ST_H, 16'd7), M_ALL, 1'b1);

    // Another illegal opcode from the unused range.
    do_reset(1);
    run_vec(mk(r4(), r1(), 1'b1, O_FETCHED, ST_F, 16'd0), M_ALL, 1'b1);
    run_vec(mk(4'($urandom_range(7, 14)), r1(), r1(), 14'h0, ST_D, 16'd0), M_ALL, 1'b1);
    run_vec(mk(r4(), r1(), r1(), O_HALT | O_E_ILL, ST_H, 16'd0), M_ALL, 1'b1);

    // Fetch timeout: 15 request cycles without ready, then halt.
    do_reset(2);
    for (int i = 0; i < 15; i++) run_vec(mk(r4(), r1(), 1'b0, O_REQ, ST_F, 16'd0), M_ALL, 1'b1);
    for (int i = 0; i < 5; i++)
      run_vec(mk(r4(), r1(), r1(), O_HALT | O_E_TO, ST_H, 16'd0), M_ALL, 1'b1);

    // Memory timeout during LOAD.
    do_reset(1);
    run_vec(mk(r4(), r1(), 1'b1, O_FETCHED, ST_F, 16'd0), M_ALL, 1'b1);
    run_vec(mk(4'd4, r1(), r1(), 14'h0, ST_D, 16'd0), M_ALL, 1'b1);
    for (int i = 0; i < 15; i++)
      run_vec(mk(4'd4, r1(), 1'b0, O_REQ | O_ASEL, ST_M, 16'd0), M_ALL, 1'b1);
    for (int i = 0; i < 3; i++)
      run_vec(mk(4'd4, r1(), r1(), O_HALT | O_E_TO, ST_H, 16'd0), M_ALL, 1'b1);

    // Reset arriving in the WB cycle of a LOAD.
    do_reset(1);
    ret_m = 16'd0;
    gen_instr(4'd3, 1'b0, 0, 0);
    drain();
    run_vec(mk(r4(), r1(), 1'b1, O_FETCHED, ST_F, 16'd1), M_ALL, 1'b1);
    run_vec(mk(4'd4, r1(), r1(), 14'h0, ST_D, 16'd1), M_ALL, 1'b1);
    run_vec(mk(4'd4, r1(), 1'b1, O_REQ | O_ASEL, ST_M, 16'd1), M_ALL, 1'b1);
    reset = 1'b1;
    run_vec(mk(4'd4, r1(), r1(), 14'h0, ST_W, 16'd1), M_STROBE, 1'b1);
    reset = 1'b0;
    run_vec(mk(r4(), r1(), 1'b0, O_REQ, ST_F, 16'd0), M_ALL, 1'b1);

    // Random instruction streams, starting with ready on the last allowed cycle.
    do_reset(1);
    ret_m = 16'd0;
    gen_instr(4'd5, 1'b0, 14, 14);
    gen_instr(4'd4, 1'b1, 14, 14);
    drain();
    for (int n = 0; n < 200; n++) begin
      gen_instr(4'($urandom_range(0, 6)), r1(), pick_delay(), pick_delay());
      drain();
    end
    checks++;
    if (retired !== ret_m) begin
      errors++;
      $display("FAIL final_retired: got %0d expected %0d", retired, ret_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
